// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in FIX.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc;
    logic        sign_a, sign_b, is_div;
    logic        arith, neg_a, neg_b;
    logic [31:0] abs_a, abs_b, quo, rem;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] mul_next, div_next, prod;
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        arith    = ~op[2];
        neg_a    = ~op[0] & op_a[31];
        neg_b    = ~op[0] & op_b[31];
        abs_a    = neg_a ? -op_a : op_a;
        abs_b    = neg_b ? -op_b : op_b;
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mag_a : 32'd0};
        mul_next = {mul_sum, acc[31:1]};
        div_sh   = {acc[63:32], acc[31]};
        div_diff = div_sh - {1'b0, mag_b};
        div_next = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
        prod     = (sign_a ^ sign_b) ? -acc : acc;
        quo      = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        rem      = sign_a ? -acc[63:32] : acc[63:32];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (op == 3'd4)
                        hi <= op_a;
                    else if (op == 3'd5)
                        lo <= op_a;
                    else if (arith) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        is_div <= op[1];
                        acc    <= {32'd0, op[1] ? abs_a : abs_b};
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= op[1] ? DIV : MUL;
                    end
                end
                FIX: begin
                    hi    <= is_div ? rem : prod[63:32];
                    lo    <= is_div ? quo : prod[31:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    acc   <= (state == DIV) ? div_next : mul_next;
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'd31) ? FIX : state;
                end
            endcase
        end
    end
endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Iterative multiply/divide unit with its own HI/LO register pair. It sits directly downstream of the register file. Its operands are the file's two read ports (rs on `data_r1`, rt on `data_r2`). It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO feed the writeback mux for MFHI/MFLO, and `busy` stalls the controller.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `start` input, 1 bit: request; sampled on the rising edge; accepted only when `busy`=0.
- `op` input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored (no effect).
- `op_a` input, 32 bits: rs value (multiplicand / dividend / MT source).
- `op_b` input, 32 bits: rt value (multiplier / divisor).
- `busy` output, 1 bit: operation in progress; new starts ignored.
- `done` output, 1 bit: one-cycle pulse when a MULT/DIV result lands in HI/LO.
- `hi` output, 32 bits: HI register.
- `lo` output, 32 bits: LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **Reset:** asserting `reset` at any time, including mid-operation:
  - state goes to IDLE;
  - `hi`, `lo`, `busy` and `done` go to 0;
  - the iteration counter and internal registers go to 0;
  - the aborted operation leaves no trace.
- **IDLE, `start`=1, MT op:**
  - MTHI: `hi`←`op_a` on that edge.
  - MTLO: `lo`←`op_a` on that edge.
  - Stay in IDLE; `busy` and `done` stay 0.
- **IDLE, `start`=1, MULT/MULTU/DIV/DIVU:**
  - Latch operand magnitudes and the sign flags.
  - Signed ops take the two's-complement absolute value; abs(0x80000000)=0x80000000 as unsigned.
  - Unsigned ops use the raw values with sign flags 0.
  - Clear the counter and go to MUL or DIV.
- **MUL:** 32 shift-add steps, one per cycle, on a 64-bit accumulator. Unsigned 32×32→64. Then go to FIX.
- **DIV:** 32 restoring steps, one per cycle: shift the remainder left, trial-subtract the divisor, set the quotient bit. Then go to FIX.
- **Divide by zero:** iterations still run, and the result is defined as remainder = dividend magnitude, quotient = 0xFFFFFFFF. The sign fix-up still applies.
- **FIX:**
  - MUL: negate the 64-bit product when the operand signs differ (signed only). HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend was negative.
  - Pulse `done` and return to IDLE.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Start while busy:** `start` while `busy`=1, or in FIX, is ignored. It is not queued and HI/LO are unaffected.
- **Hold:** HI/LO change only in FIX, on MTHI/MTLO, or on reset. They hold their value during MUL and DIV.

## Timing
- Let E0 be the edge that accepts a MULT/DIV.
- `busy` is 1 from just after E0 until just after E33.
- The iteration steps occur on edges E1..E32.
- FIX executes on E33: `hi`/`lo` take their result values, `busy` falls to 0 and `done` is 1 for exactly the cycle between E33 and E34.
- Total latency is 33 cycles from acceptance to a valid result. This is the same for every operand value, including zero divisors.
- A new `start` is accepted at E34 at the earliest. `start` asserted during the E33–E34 done cycle is accepted at E34.
- MTHI/MTLO: result is visible 1 cycle after the accepting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset is asynchronous: outputs are 0 within the same cycle reset rises, with no clock edge needed. Release is synchronous to the next edge.

## Test plan
- **MULT:** `op_a`=0xFFFFFFFD (−3), `op_b`=5 → at E33 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done`=1 for one cycle, `busy` high for exactly 33 cycles.
- **MULTU:** `op_a`=`op_b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. The same operands with MULT → `hi`=0, `lo`=1.
- **DIV:** −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **DIVU:** 100 / 7 → `lo`=14, `hi`=2.
- **DIVU divide-by-zero:** 0x1234 / 0 → `hi`=0x1234, `lo`=0xFFFFFFFF after the standard 33 cycles.
- **Ignored starts, then MT ops:** start a MULT 6×7. Pulse `start` with DIVU 9/3 at E10 → ignored; E33 gives `hi`=0, `lo`=42. Then MTHI 0xDEADBEEF → `hi`=0xDEADBEEF the next cycle, `lo` unchanged, `done` stays 0.
- **Reset mid-operation:** assert `reset` asynchronously at E15 of a DIV, with no clock edge → `busy`, `done`, `hi` and `lo` are 0 immediately. After release, a MULTU 3×4 completes with `lo`=12 after 33 cycles.
